// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and byte helpers for the byte-serial memory controller.
// The `True/`False guards let this file coexist with an earlier definition.
`ifndef True
`define True 1'b1
`endif
`ifndef False
`define False 1'b0
`endif

package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    function automatic logic [2:0] decode_len(input logic [2:0] len);
        case (len)
            LEN_B:   return LEN_B;
            LEN_H:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

    // Byte 0 starts a fresh word so short loads come out zero-extended.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = (idx == 2'd0) ? 32'd0 : word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word,
                                            input logic [1:0]  idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter between IF fetches / MEM loads-stores and an 8-bit
// synchronous RAM. One access in flight; MEM wins over IF.
`ifndef True
`define True 1'b1
`endif
`ifndef False
`define False 1'b0
`endif

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_e            state_q;
    owner_e            owner_q;
    logic [2:0]        cnt_q;
    logic [2:0]        len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_inst_q;
    logic [31:0]       mem_rdata_q;
    logic [1:0]        cap_idx;

    // RAM data lags the address by one cycle, so the byte arriving now is cnt-1.
    assign cap_idx = cnt_q[1:0] - 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else if (rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        owner_q <= OWN_MEM;
                        addr_q  <= mem_addr;
                        len_q   <= decode_len(mem_len);
                        wdata_q <= mem_wdata;
                        cnt_q   <= 3'd0;
                        state_q <= mem_we ? ST_WR : ST_RD;
                    end else if (if_req && !clr) begin
                        owner_q <= OWN_IF;
                        addr_q  <= if_addr;
                        len_q   <= LEN_W;
                        wdata_q <= 32'd0;
                        cnt_q   <= 3'd0;
                        state_q <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (owner_q == OWN_IF && clr) begin
                        cnt_q   <= 3'd0;
                        state_q <= ST_IDLE;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            if (owner_q == OWN_IF)
                                if_inst_q <= put_byte(if_inst_q, cap_idx, ram_din);
                            else
                                mem_rdata_q <= put_byte(mem_rdata_q, cap_idx, ram_din);
                        end
                        if (cnt_q == len_q)
                            state_q <= ST_DONE;
                        else
                            cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_WR: begin
                    if (cnt_q == len_q - 3'd1)
                        state_q <= ST_DONE;
                    else
                        cnt_q <= cnt_q + 3'd1;
                end
                ST_DONE: begin
                    cnt_q   <= 3'd0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_a    = '0;
        ram_dout = 8'd0;
        ram_wr   = `False;
        if_done  = `False;
        mem_done = `False;
        case (state_q)
            ST_RD: begin
                if (cnt_q < len_q)
                    ram_a = addr_q + ADDR_W'(cnt_q);
            end
            ST_WR: begin
                ram_a    = addr_q + ADDR_W'(cnt_q);
                ram_dout = get_byte(wdata_q, cnt_q[1:0]);
                ram_wr   = rdy;
            end
            ST_DONE: begin
                // A flush landing on the IF completion cycle cancels the pulse.
                if (owner_q == OWN_IF && !clr)
                    if_done = `True;
                if (owner_q == OWN_MEM)
                    mem_done = `True;
            end
            default: ;
        endcase
    end

    assign if_inst   = if_inst_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: expected completions are queued at issue time
// and a negedge monitor pops and compares them as done pulses appear.
`timescale 1ns/1ps

module tb_mem_ctrl;

    localparam int EW = 65;
    localparam int HN = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  mem_len = 3'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        if_done, mem_done, ram_wr;
    logic [31:0] if_inst, mem_rdata, ram_a;
    logic [7:0]  ram_din, ram_dout;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [31:0]   last_rdata = 32'd0;

    wire [106:0] all_outs = {if_done, mem_done, if_inst, mem_rdata, ram_a, ram_dout, ram_wr};

    always @(posedge clk) cyc <= cyc + 1;

    // 4 KiB synchronous RAM model; only the low 12 address bits decode.
    logic [7:0]  ram [0:HN-1];
    logic        poke_en = 1'b0;
    logic [11:0] poke_a = 12'd0;
    logic [7:0]  poke_d = 8'd0;

    always @(posedge clk) begin
        if (poke_en)
            ram[poke_a] <= poke_d;
        else if (ram_wr)
            ram[ram_a[11:0]] <= ram_dout;
        ram_din <= ram[ram_a[11:0]];
    end

    logic [31:0] a_hist [0:HN-1];
    logic        w_hist [0:HN-1];
    logic [7:0]  d_hist [0:HN-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc < HN) begin
            a_hist[cyc] <= ram_a;
            w_hist[cyc] <= ram_wr;
            d_hist[cyc] <= ram_dout;
        end
        if (rst_n && (if_done || mem_done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {if_done, mem_done}, 2'b00);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_owner", {if_done, mem_done}, mon_e[64] ? 2'b01 : 2'b10);
                check("done_data", mon_e[64] ? mem_rdata : if_inst, mon_e[63:32]);
                check("done_cycle", cyc, mon_e[31:0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        step(1);
        poke_en = 1'b0;
    endtask

    task automatic expect_done(input bit is_mem, input logic [31:0] data, input int c);
        exp_q.push_back({is_mem, data, 32'(c)});
    endtask

    task automatic start_if(input logic [31:0] a, output int k);
        step(1);
        if_addr = a;
        if_req  = 1'b1;
        k = cyc;
    endtask

    task automatic start_mem(input bit we, input logic [2:0] len, input logic [31:0] a,
                             input logic [31:0] wd, output int k);
        step(1);
        mem_we    = we;
        mem_len   = len;
        mem_addr  = a;
        mem_wdata = wd;
        mem_req   = 1'b1;
        k = cyc;
    endtask

    task automatic wait_done(input bit is_mem, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = is_mem ? mem_done : if_done;
        end
        check(is_mem ? "mem_done_seen" : "if_done_seen", seen, 1'b1);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        logic [31:0] wd;
        logic [31:0] wa [4];

        #1 rst_n = 1'b0;
        #1 check("reset_outputs", all_outs, 107'd0);
        step(3);
        rst_n = 1'b1;
        step(2);
        check("idle_outputs", all_outs, 107'd0);

        poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
        poke(12'h300, 8'h80);
        poke(12'h304, 8'h93); poke(12'h305, 8'h00); poke(12'h306, 8'h10); poke(12'h307, 8'h00);

        // IF fetch: four address steps, completion six cycles after the request.
        start_if(32'h100, k);
        expect_done(1'b0, 32'h0000_0513, k + 6);
        wait_done(1'b0, 20);
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) check("if_ram_a", a_hist[k+1+i], 32'h100 + i);
        check("if_ram_a_idle", a_hist[k+5], 32'd0);

        // Word store: four write cycles, little-endian byte order.
        wd = 32'hDEAD_BEEF;
        start_mem(1'b1, 3'd4, 32'h200, wd, k);
        expect_done(1'b1, last_rdata, k + 5);
        wait_done(1'b1, 20);
        mem_req = 1'b0;
        for (int i = 0; i < 4; i++)
            check("st_bus", {w_hist[k+1+i], a_hist[k+1+i], d_hist[k+1+i]},
                  {1'b1, 32'h200 + i, wd[8*i +: 8]});
        check("st_wr_end", w_hist[k+5], 1'b0);

        // Halfword load, then an illegal length that must act as a word.
        start_mem(1'b0, 3'd2, 32'h200, 32'd0, k);
        expect_done(1'b1, 32'h0000_BEEF, k + 4);
        wait_done(1'b1, 20);
        mem_req = 1'b0;
        start_mem(1'b0, 3'd7, 32'h200, 32'd0, k);
        expect_done(1'b1, 32'hDEAD_BEEF, k + 6);
        wait_done(1'b1, 20);
        mem_req = 1'b0;

        // Simultaneous requests: byte load first, fetch accepted after its DONE.
        step(1);
        mem_we = 1'b0; mem_len = 3'd1; mem_addr = 32'h300; mem_req = 1'b1;
        if_addr = 32'h304; if_req = 1'b1;
        k = cyc;
        expect_done(1'b1, 32'h0000_0080, k + 3);
        expect_done(1'b0, 32'h0010_0093, k + 10);
        wait_done(1'b1, 20);
        mem_req = 1'b0;
        wait_done(1'b0, 20);
        if_req = 1'b0;
        last_rdata = 32'h0000_0080;
        check("arb_if_start", a_hist[k+5], 32'h304);

        // Flush during RD at cnt=2 aborts; the held request restarts at byte 0.
        start_if(32'h100, k);
        expect_done(1'b0, 32'h0000_0513, k + 10);
        step(3);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        wait_done(1'b0, 20);
        if_req = 1'b0;
        check("clr_ram_a_before", a_hist[k+3], 32'h102);
        check("clr_ram_a_idle", a_hist[k+4], 32'd0);
        check("clr_restart", a_hist[k+5], 32'h100);

        // Flush on the IF DONE cycle suppresses the pulse but the word is captured.
        start_if(32'h304, k);
        step(6);
        clr = 1'b1;
        @(negedge clk);
        check("clr_done_gated", if_done, 1'b0);
        check("clr_done_inst", if_inst, 32'h0010_0093);
        step(1);
        clr = 1'b0;
        if_req = 1'b0;

        // Three-cycle freeze while the store sits at cnt=1.
        wd = 32'h1122_3344;
        start_mem(1'b1, 3'd4, 32'h400, wd, k);
        expect_done(1'b1, last_rdata, k + 8);
        step(2);
        rdy = 1'b0;
        step(3);
        rdy = 1'b1;
        wait_done(1'b1, 20);
        mem_req = 1'b0;
        check("frz_first", {w_hist[k+1], a_hist[k+1], d_hist[k+1]}, {1'b1, 32'h400, 8'h44});
        for (int i = 2; i <= 4; i++) check("frz_no_wr", w_hist[k+i], 1'b0);
        for (int i = 1; i < 4; i++)
            check("frz_resume", {w_hist[k+4+i], a_hist[k+4+i], d_hist[k+4+i]},
                  {1'b1, 32'h400 + i, wd[8*i +: 8]});
        start_mem(1'b0, 3'd4, 32'h400, 32'd0, k);
        expect_done(1'b1, 32'h1122_3344, k + 6);
        wait_done(1'b1, 20);
        mem_req = 1'b0;

        // Reset in the middle of a load: everything clears, no done follows.
        start_mem(1'b0, 3'd4, 32'h100, 32'd0, k);
        step(3);
        rst_n = 1'b0;
        #1 check("midload_reset_outputs", all_outs, 107'd0);
        mem_req = 1'b0;
        step(2);
        rst_n = 1'b1;
        poke(12'hFFE, 8'h78); poke(12'hFFF, 8'h56); poke(12'h000, 8'h34); poke(12'h001, 8'h12);

        // Word load that wraps the top of the address space.
        wa = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        start_mem(1'b0, 3'd4, 32'hFFFF_FFFE, 32'd0, k);
        expect_done(1'b1, 32'h1234_5678, k + 6);
        wait_done(1'b1, 20);
        mem_req = 1'b0;
        for (int i = 0; i < 4; i++) check("wrap_ram_a", a_hist[k+1+i], wa[i]);

        step(5);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
